// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus: one-cycle grant pulse, ownership tracking
// until end of burst, and begin/burst watchdogs that force a release.
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS   = 4,
  parameter int unsigned BEGIN_TIMEOUT = 16,
  parameter int unsigned BURST_TIMEOUT = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [2:0]             ownerId,
  output logic                   busBusy,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   busErrorIn,
  output logic                   endTransactionOut,
  output logic                   busErrorOut,
  output logic [7:0]             timeoutCount
);

  localparam int unsigned PTR_W = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TC_W  = 8;
  // WAIT_BEGIN is entered one cycle after the grant, so its limit is two short of the timeout.
  localparam logic [CNT_W-1:0] BEGIN_LAST = CNT_W'(BEGIN_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_TIMEOUT - 1);
  localparam logic [TC_W-1:0]  TC_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT      = 3'd1,
    WAIT_BEGIN = 3'd2,
    ACTIVE     = 3'd3,
    FORCE      = 3'd4
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_pointer;
  logic [CNT_W-1:0] cnt;
  logic             win_valid_c;
  logic [PTR_W-1:0] win_idx_c;
  int               best_dist_c;
  int               dist_c;

  // Winner is the requester closest after rr_pointer in circular order.
  always_comb begin
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    best_dist_c = int'(NUM_MASTERS);
    dist_c      = 0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      dist_c = (i + int'(NUM_MASTERS) - 1 - int'(rr_pointer)) % int'(NUM_MASTERS);
      if (request[i] && (dist_c < best_dist_c)) begin
        best_dist_c = dist_c;
        win_valid_c = 1'b1;
        win_idx_c   = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      grant             <= '0;
      ownerId           <= '0;
      busBusy           <= 1'b0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      timeoutCount      <= '0;
      rr_pointer        <= PTR_W'(NUM_MASTERS - 1);
      cnt               <= '0;
    end else begin
      grant             <= '0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (win_valid_c) begin
            grant      <= NUM_MASTERS'(1) << win_idx_c;
            ownerId    <= win_idx_c;
            rr_pointer <= win_idx_c;
            busBusy    <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          cnt <= '0;
          if (beginTransactionIn && endTransactionIn) begin
            busBusy <= 1'b0;
            state   <= IDLE;
          end else if (beginTransactionIn) begin
            state <= ACTIVE;
          end else begin
            state <= WAIT_BEGIN;
          end
        end
        WAIT_BEGIN: begin
          if (beginTransactionIn && endTransactionIn) begin
            cnt     <= '0;
            busBusy <= 1'b0;
            state   <= IDLE;
          end else if (beginTransactionIn) begin
            cnt   <= '0;
            state <= ACTIVE;
          end else if (cnt >= BEGIN_LAST) begin
            cnt          <= '0;
            busBusy      <= 1'b0;
            timeoutCount <= (timeoutCount == TC_MAX) ? timeoutCount : timeoutCount + TC_W'(1);
            state        <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACTIVE: begin
          // A slave error alone keeps ownership; only the end strobe or the watchdog releases.
          if (endTransactionIn) begin
            cnt     <= '0;
            busBusy <= 1'b0;
            state   <= IDLE;
          end else if (cnt >= BURST_LAST) begin
            cnt               <= '0;
            endTransactionOut <= 1'b1;
            busErrorOut       <= 1'b1;
            timeoutCount      <= (timeoutCount == TC_MAX) ? timeoutCount : timeoutCount + TC_W'(1);
            state             <= FORCE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FORCE: begin
          cnt     <= '0;
          busBusy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          cnt     <= '0;
          busBusy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
